// File: rtl/spi_register_bank.sv
// Register bank behind the SPI slave: ID, status, W1C IRQ flags with mask, general config registers.
// Define SPI_REGISTER_BANK_SHADOW_EN for shadowed general registers committed at transaction end.
module spi_register_bank #(
   parameter int          NUM_REGISTERS = 32,
   parameter int          ADDRESS_WIDTH = $clog2(NUM_REGISTERS),
   parameter logic [7:0]  DEVICE_ID     = 8'hA5
) (
   input  logic                            CLK,
   input  logic                            RESET_N,
   input  logic                            SSEL,
   input  logic [ADDRESS_WIDTH-1:0]        ADDRESS,
   input  logic [7:0]                      WRITE_DATA,
   input  logic                            WREN,
   output logic [7:0]                      READ_DATA,
   input  logic [7:0]                      EVENT_IN,
   output logic                            IRQ,
   output logic [8*(NUM_REGISTERS-8)-1:0]  CFG_OUT,
   output logic                            COMMIT
);

   localparam logic [ADDRESS_WIDTH-1:0] A_ID     = ADDRESS_WIDTH'(0);
   localparam logic [ADDRESS_WIDTH-1:0] A_STATUS = ADDRESS_WIDTH'(1);
   localparam logic [ADDRESS_WIDTH-1:0] A_FLAGS  = ADDRESS_WIDTH'(2);
   localparam logic [ADDRESS_WIDTH-1:0] A_MASK   = ADDRESS_WIDTH'(3);
   localparam logic [ADDRESS_WIDTH-1:0] A_GEN    = ADDRESS_WIDTH'(8);

   logic [7:0] r_flags;
   logic [7:0] r_mask;
   logic       r_irq;
   logic [7:0] w_status;
   logic       w_wr_gen;
   logic       w_wr_flags;
   logic       w_wr_mask;

   // General registers indexed directly by address; reg 8 lands in the low byte of CFG_OUT.
   logic [NUM_REGISTERS-1:8][7:0] r_live;

   assign w_wr_gen   = WREN && (ADDRESS >= A_GEN);
   assign w_wr_flags = WREN && (ADDRESS == A_FLAGS);
   assign w_wr_mask  = WREN && (ADDRESS == A_MASK);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_flags <= '0;
         r_mask  <= '0;
         r_irq   <= 1'b0;
      end else begin
         // Clear first, then set, so a same-cycle event wins over a W1C.
         r_flags <= (r_flags & ~(w_wr_flags ? WRITE_DATA : 8'h00)) | EVENT_IN;
         if (w_wr_mask) r_mask <= WRITE_DATA;
         r_irq <= |(r_flags & r_mask);
      end
   end

`ifdef SPI_REGISTER_BANK_SHADOW_EN
   logic [NUM_REGISTERS-1:8][7:0] r_shadow;
   logic [NUM_REGISTERS-1:8][7:0] w_shadow_next;
   logic [1:0]                    r_ssel_sync;
   logic                          r_ssel_prev;
   logic                          r_dirty;
   logic                          r_commit;
   logic [5:0]                    r_commit_cnt;
   logic                          w_txn_end;
   logic                          w_do_commit;

   always_comb begin
      w_shadow_next = r_shadow;
      if (w_wr_gen) w_shadow_next[ADDRESS] = WRITE_DATA;
   end

   assign w_txn_end   = r_ssel_sync[1] & ~r_ssel_prev;
   assign w_do_commit = w_txn_end & r_dirty;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_ssel_sync  <= '1;
         r_ssel_prev  <= 1'b1;
         r_shadow     <= '0;
         r_live       <= '0;
         r_dirty      <= 1'b0;
         r_commit     <= 1'b0;
         r_commit_cnt <= '0;
      end else begin
         r_ssel_sync <= {r_ssel_sync[0], SSEL};
         r_ssel_prev <= r_ssel_sync[1];
         r_shadow    <= w_shadow_next;
         r_commit    <= w_do_commit;
         // Commit copies the next shadow so a write on the closing edge is included.
         if (w_do_commit) begin
            r_live       <= w_shadow_next;
            r_commit_cnt <= r_commit_cnt + 6'd1;
            r_dirty      <= 1'b0;
         end else if (w_wr_gen) begin
            r_dirty <= 1'b1;
         end
      end
   end

   assign COMMIT   = r_commit;
   assign w_status = {r_commit_cnt, r_dirty, r_irq};
`else
   logic w_unused_ssel;

   assign w_unused_ssel = SSEL;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_live <= '0;
      end else if (w_wr_gen) begin
         r_live[ADDRESS] <= WRITE_DATA;
      end
   end

   assign COMMIT   = 1'b0;
   assign w_status = {7'b0, r_irq};
`endif

   always_comb begin
      READ_DATA = 8'h00;
      if (ADDRESS >= A_GEN) begin
`ifdef SPI_REGISTER_BANK_SHADOW_EN
         READ_DATA = r_shadow[ADDRESS];
`else
         READ_DATA = r_live[ADDRESS];
`endif
      end else begin
         case (ADDRESS)
            A_ID:     READ_DATA = DEVICE_ID;
            A_STATUS: READ_DATA = w_status;
            A_FLAGS:  READ_DATA = r_flags;
            A_MASK:   READ_DATA = r_mask;
            default:  READ_DATA = 8'h00;
         endcase
      end
   end

   assign IRQ     = r_irq;
   assign CFG_OUT = r_live;

endmodule

// File: tb/tb_spi_register_bank.sv
// Self-checking bench for spi_register_bank: vector table, hand sequences, randomized traffic vs model.
module tb_spi_register_bank;

   localparam int NR = 32;
   localparam int AW = 5;
   localparam int NG = NR - 8;
`ifdef SPI_REGISTER_BANK_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RESET_N;
   logic            SSEL;
   logic [AW-1:0]   ADDRESS;
   logic [7:0]      WRITE_DATA;
   logic            WREN;
   logic [7:0]      READ_DATA;
   logic [7:0]      EVENT_IN;
   logic            IRQ;
   logic [8*NG-1:0] CFG_OUT;
   logic            COMMIT;

   spi_register_bank #(
      .NUM_REGISTERS (NR),
      .DEVICE_ID     (8'hA5)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .SSEL       (SSEL),
      .ADDRESS    (ADDRESS),
      .WRITE_DATA (WRITE_DATA),
      .WREN       (WREN),
      .READ_DATA  (READ_DATA),
      .EVENT_IN   (EVENT_IN),
      .IRQ        (IRQ),
      .CFG_OUT    (CFG_OUT),
      .COMMIT     (COMMIT)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [7:0]  m_live   [NR];
   logic [7:0]  m_shadow [NR];
   logic [7:0]  m_flags, m_mask;
   bit          m_irq, m_commit, m_dirty;
   int unsigned m_cnt;
   bit          m_s1, m_s2, m_s3;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NR; i++) begin
         m_live[i]   = 8'h00;
         m_shadow[i] = 8'h00;
      end
      m_flags = 8'h00; m_mask = 8'h00;
      m_irq = 0; m_commit = 0; m_dirty = 0; m_cnt = 0;
      m_s1 = 1; m_s2 = 1; m_s3 = 1;
   endtask

   function automatic logic [7:0] m_read(input int a);
      logic [5:0] c;
      c = 6'(m_cnt);
      if (a == 0) return 8'hA5;
      if (a == 1) return SHADOW ? {c, m_dirty, m_irq} : {7'b0, m_irq};
      if (a == 2) return m_flags;
      if (a == 3) return m_mask;
      if (a < 8) return 8'h00;
      return SHADOW ? m_shadow[a] : m_live[a];
   endfunction

   function automatic logic [8*NG-1:0] m_cfg();
      logic [8*NG-1:0] r;
      r = '0;
      for (int i = 8; i < NR; i++) r[(i-8)*8 +: 8] = m_live[i];
      return r;
   endfunction

   // One clock edge of the specification's behaviour.
   task automatic m_edge(input int a, input logic [7:0] d, input bit we, input logic [7:0] ev, input bit ss);
      bit irq_n, ended;
      irq_n = |(m_flags & m_mask);
      ended = m_s2 && !m_s3;   // synced SSEL rose: sampled high two edges back, low three back
      if (we && a == 2) m_flags = m_flags & ~d;
      m_flags = m_flags | ev;
      if (we && a == 3) m_mask = d;
      m_commit = 0;
      if (SHADOW) begin
         if (we && a >= 8) m_shadow[a] = d;
         if (ended && m_dirty) begin
            for (int i = 8; i < NR; i++) m_live[i] = m_shadow[i];
            m_cnt = (m_cnt + 1) % 64;
            m_dirty = 0;
            m_commit = 1;
         end else if (we && a >= 8) begin
            m_dirty = 1;
         end
      end else if (we && a >= 8) begin
         m_live[a] = d;
      end
      m_irq = irq_n;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = ss;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input int a, input logic [7:0] d, input bit we, input logic [7:0] ev, input bit ss);
      ADDRESS = AW'(a); WRITE_DATA = d; WREN = we; EVENT_IN = ev; SSEL = ss;
      #1;
      chk("rd_pre", READ_DATA, m_read(a));
      @(posedge CLK);
      m_edge(a, d, we, ev, ss);
      @(negedge CLK);
      chk("cfg", CFG_OUT, m_cfg());
      chk("irq", IRQ, m_irq);
      chk("commit", COMMIT, m_commit);
   endtask

   typedef struct {
      int         addr;
      logic [7:0] wd;
      bit         we;
      logic [7:0] ev;
      logic [7:0] rd;
      bit         irq;
   } vec_t;

   vec_t tbl [14];
   int   pulses;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0,  8'h00, 0, 8'h00, 8'hA5, 0};
      tbl[1]  = '{5,  8'h00, 0, 8'h00, 8'h00, 0};
      tbl[2]  = '{0,  8'h55, 1, 8'h00, 8'hA5, 0};
      tbl[3]  = '{3,  8'h05, 1, 8'h00, 8'h05, 0};
      tbl[4]  = '{2,  8'h00, 0, 8'h06, 8'h06, 0};
      tbl[5]  = '{2,  8'h00, 0, 8'h00, 8'h06, 1};
      tbl[6]  = '{2,  8'h04, 1, 8'h00, 8'h02, 1};
      tbl[7]  = '{2,  8'h00, 0, 8'h00, 8'h02, 0};
      tbl[8]  = '{2,  8'h01, 1, 8'h01, 8'h03, 0};
      tbl[9]  = '{2,  8'h00, 0, 8'h00, 8'h03, 1};
      tbl[10] = '{2,  8'h03, 1, 8'h00, 8'h00, 1};
      tbl[11] = '{2,  8'h00, 0, 8'h00, 8'h00, 0};
      tbl[12] = '{4,  8'hFF, 1, 8'h00, 8'h00, 0};
      tbl[13] = '{3,  8'h00, 1, 8'h00, 8'h00, 0};

      RESET_N = 0; SSEL = 1; WREN = 0; ADDRESS = '0; WRITE_DATA = '0; EVENT_IN = '0;
      m_reset();
      repeat (2) @(negedge CLK);
      RESET_N = 1;
      ADDRESS = AW'(3);
      #1;
      chk("reset_rd_mask", READ_DATA, 8'h00);
      chk("reset_cfg", CFG_OUT, '0);
      chk("reset_irq", IRQ, 1'b0);
      chk("reset_commit", COMMIT, 1'b0);
      @(negedge CLK);

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].addr, tbl[i].wd, tbl[i].we, tbl[i].ev, 1'b1);
         chk($sformatf("tbl%0d_rd", i), READ_DATA, tbl[i].rd);
         chk($sformatf("tbl%0d_irq", i), IRQ, tbl[i].irq);
      end

`ifdef SPI_REGISTER_BANK_SHADOW_EN
      repeat (3) step(0, 8'h00, 0, 8'h00, 0);
      step(8, 8'hFA, 1, 8'h00, 0);
      step(9, 8'hCE, 1, 8'h00, 0);
      chk("atomic_hold", CFG_OUT[15:0], 16'h0000);
      step(8, 8'h00, 0, 8'h00, 0);
      chk("shadow_rd8", READ_DATA, 8'hFA);
      step(9, 8'h00, 0, 8'h00, 0);
      chk("shadow_rd9", READ_DATA, 8'hCE);
      step(1, 8'h00, 0, 8'h00, 1);
      chk("edge1_commit", COMMIT, 1'b0);
      step(1, 8'h00, 0, 8'h00, 1);
      chk("edge2_commit", COMMIT, 1'b0);
      chk("edge2_cfg", CFG_OUT[15:0], 16'h0000);
      step(1, 8'h00, 0, 8'h00, 1);
      chk("edge3_cfg", CFG_OUT[15:0], 16'hCEFA);
      chk("edge3_commit", COMMIT, 1'b1);
      step(1, 8'h00, 0, 8'h00, 1);
      chk("edge4_commit", COMMIT, 1'b0);
      chk("status_after_commit", READ_DATA, 8'h04);

      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 8'h00, 0, 8'h00, (i >= 3));
         pulses += int'(COMMIT);
      end
      chk("noop_pulses", pulses, 0);
      chk("noop_status", READ_DATA, 8'h04);

      for (int t = 0; t < 63; t++) begin
         step(0, 8'h00, 0, 8'h00, 0);
         step(0, 8'h00, 0, 8'h00, 0);
         step(10 + (t % 8), 8'(t), 1, 8'h00, 0);
         repeat (4) step(1, 8'h00, 0, 8'h00, 1);
         if (t == 61) chk("cnt_63", READ_DATA[7:2], 6'd63);
      end
      chk("cnt_wrap", READ_DATA[7:2], 6'd0);
`else
      step(8, 8'hFA, 1, 8'h00, 1);
      chk("direct_cfg", CFG_OUT[7:0], 8'hFA);
      chk("direct_rd", READ_DATA, 8'hFA);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 8'h00, 0, 8'h00, (i >= 3));
         pulses += int'(COMMIT);
      end
      chk("no_commit_pulses", pulses, 0);
      chk("status_plain", READ_DATA, 8'h00);
`endif

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, NR-1), 8'($urandom), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
              ($urandom_range(0, 7) == 0) ? ~SSEL : SSEL);
      end

      WREN = 1; WRITE_DATA = 8'h3C; EVENT_IN = 8'hFF;
      #3 RESET_N = 0;
      #1 ADDRESS = AW'(3);
      #1;
      chk("midreset_rd_mask", READ_DATA, 8'h00);
      chk("midreset_cfg", CFG_OUT, '0);
      chk("midreset_irq", IRQ, 1'b0);
      chk("midreset_commit", COMMIT, 1'b0);
      m_reset();
      WREN = 0; EVENT_IN = 8'h00; SSEL = 1;
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1;

      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, NR-1), 8'($urandom), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
              ($urandom_range(0, 5) == 0) ? ~SSEL : SSEL);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
